// File: rtl/epoch_tv1.sv
// Epoch TV-1 video display processor: CPU bus decode, internal chr/bgm/oam memories,
// external VRAM routing, raster timing and the text/BG layer rendered to 24-bit RGB.
`timescale 1ns/1ps
module epoch_tv1 (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [12:0] A,
  input  logic [7:0]  DB_I,
  output logic [7:0]  DB_O,
  output logic        DB_OE,
  input  logic        RDB,
  input  logic        WRB,
  input  logic        CSB,
  output logic [11:0] VAA,
  input  logic [7:0]  VAD_I,
  output logic [7:0]  VAD_O,
  output logic        nVARD,
  output logic        nVAWR,
  output logic [11:0] VBA,
  input  logic [7:0]  VBD_I,
  output logic [7:0]  VBD_O,
  output logic        nVBRD,
  output logic        nVBWR,
  output logic        DE,
  output logic        HS,
  output logic        VS,
  output logic [23:0] RGB
);

  typedef enum logic [2:0] {SEL_VRAM, SEL_BGM, SEL_OAM, SEL_REG, SEL_NONE} sel_e;

  localparam logic [8:0] H_LAST   = 9'd259;
  localparam logic [8:0] V_LAST   = 9'd261;
  localparam logic [8:0] H_ACTIVE = 9'd192;
  localparam logic [8:0] V_ACTIVE = 9'd256;
  localparam logic [8:0] HS_START = 9'd208;
  localparam logic [8:0] HS_END   = 9'd227;
  localparam logic [8:0] VS_START = 9'd258;
  localparam logic [8:0] VS_END   = 9'd260;

  logic [7:0]  chr  [1024];
  logic [7:0]  bgm  [512];
  logic [31:0] oam  [128];
  logic [7:0]  regs [4];

  sel_e       sel;
  logic       wr_en;
  logic       vram_sel;
  logic [7:0] rd_data;

  // ---------------- CPU bus ----------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel = SEL_NONE;
    if (!A[12])                      sel = SEL_VRAM;
    else if (A[11:9] == 3'b000)      sel = SEL_BGM;
    else if (A[11:9] == 3'b001)      sel = SEL_OAM;
    else if (A[11:2] == 10'h100)     sel = SEL_REG;
  end

  assign wr_en    = CE & ~CSB & ~WRB & ~RES;
  assign vram_sel = (sel == SEL_VRAM);
  assign DB_OE    = ~CSB & ~RDB;

  // NOTE: memory arrays carry no reset; contents survive RES and map to plain RAM.
  always_ff @(posedge CLK) begin
    if (wr_en && sel == SEL_BGM) bgm[A[8:0]] <= DB_I;
    if (wr_en && sel == SEL_OAM) oam[A[8:2]][{A[1:0], 3'b000} +: 8] <= DB_I;
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (wr_en && sel == SEL_REG) begin
      regs[A[1:0]] <= DB_I;
    end
  end

  always_comb begin
    rd_data = 8'hFF;
    unique case (sel)
      SEL_VRAM: rd_data = A[0] ? VBD_I : VAD_I;
      SEL_BGM:  rd_data = bgm[A[8:0]];
      SEL_OAM:  rd_data = oam[A[8:2]][{A[1:0], 3'b000} +: 8];
      SEL_REG:  rd_data = regs[A[1:0]];
      default:  rd_data = 8'hFF;
    endcase
  end

  // External VRAM answers one CLK after the strobe, so the second edge captures it.
  always_ff @(posedge CLK) begin
    if (RES)              DB_O <= '0;
    else if (~CSB & ~RDB) DB_O <= rd_data;
  end

  assign VAA   = {1'b0, A[11:1]};
  assign VBA   = {1'b0, A[11:1]};
  assign VAD_O = DB_I;
  assign VBD_O = DB_I;
  assign nVARD = CSB | RDB | ~vram_sel |  A[0];
  assign nVAWR = CSB | WRB | ~vram_sel |  A[0];
  assign nVBRD = CSB | RDB | ~vram_sel | ~A[0];
  assign nVBWR = CSB | WRB | ~vram_sel | ~A[0];

  // ---------------- raster timing ----------------
  logic [8:0] h, v;

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (RES) begin
      h <= '0;
      v <= '0;
    end else if (CE) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 9'd1;
      end else begin
        h <= h + 9'd1;
      end
    end
  end

  // ---------------- render pipeline: stage 1 fetches the map code ----------------
  logic [6:0] code_q;
  logic [2:0] pix_q;
  logic [2:0] line_q;
  logic       de1, hs1, vs1;

  always_ff @(posedge CLK) begin
    if (CE) begin
      code_q <= bgm[{v[7:4], h[7:3]}][6:0];
      pix_q  <= h[2:0];
      line_q <= v[3:1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      de1 <= 1'b0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
    end else if (CE) begin
      de1 <= (h < H_ACTIVE) && (v < V_ACTIVE);
      hs1 <= (h >= HS_START) && (h <= HS_END);
      vs1 <= (v >= VS_START) && (v <= VS_END);
    end
  end

  // ---------------- stage 2: glyph bit, colour index, palette ----------------
  function automatic logic [23:0] palette(input logic [3:0] idx);
    logic [7:0] hi, lo;
    hi = idx[3] ? 8'hFF : 8'hAA;
    lo = idx[3] ? 8'h55 : 8'h00;
    return {idx[2] ? hi : lo, idx[1] ? hi : lo, idx[0] ? hi : lo};
  endfunction

  logic [7:0]  chr_byte;
  logic        px;
  logic [3:0]  idx;
  logic [23:0] pixel_rgb;

  always_comb begin
    chr_byte  = chr[{code_q, line_q}];
    px        = chr_byte[3'd7 - pix_q];
    idx       = regs[1][3:0];
    if (regs[0][1] && px) idx = regs[1][7:4];
    pixel_rgb = (regs[0][0] && de1) ? palette(idx) : 24'h0;
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      DE  <= 1'b0;
      HS  <= 1'b0;
      VS  <= 1'b0;
      RGB <= '0;
    end else if (CE) begin
      DE  <= de1;
      HS  <= hs1;
      VS  <= vs1;
      RGB <= pixel_rgb;
    end
  end

endmodule

// File: tb/tb_epoch_tv1.sv
// Directed bench for epoch_tv1: bus decode, VRAM strobes, registers, raster timing
// over one frame and pixel colour for a preloaded glyph.
`timescale 1ns/1ps
module tb_epoch_tv1;

  logic        CLK = 1'b0;
  logic        RES, CE;
  logic [12:0] A;
  logic [7:0]  DB_I, DB_O;
  logic        DB_OE, RDB, WRB, CSB;
  logic [11:0] VAA, VBA;
  logic [7:0]  VAD_I, VAD_O, VBD_I, VBD_O;
  logic        nVARD, nVAWR, nVBRD, nVBWR;
  logic        DE, HS, VS;
  logic [23:0] RGB;

  epoch_tv1 dut (
    .CLK(CLK), .RES(RES), .CE(CE), .A(A), .DB_I(DB_I), .DB_O(DB_O), .DB_OE(DB_OE),
    .RDB(RDB), .WRB(WRB), .CSB(CSB),
    .VAA(VAA), .VAD_I(VAD_I), .VAD_O(VAD_O), .nVARD(nVARD), .nVAWR(nVAWR),
    .VBA(VBA), .VBD_I(VBD_I), .VBD_O(VBD_O), .nVBRD(nVBRD), .nVBWR(nVBWR),
    .DE(DE), .HS(HS), .VS(VS), .RGB(RGB)
  );

  always #17 CLK = ~CLK;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One CLK period; inputs change just after a negedge, outputs are read there too.
  task automatic cyc(input logic ce);
    CE = ce;
    @(negedge CLK);
  endtask

  task automatic cpu_write(input logic [12:0] addr, input logic [7:0] data);
    A = addr; DB_I = data; CSB = 1'b0; WRB = 1'b0;
    cyc(1'b0); cyc(1'b1); cyc(1'b0);
    WRB = 1'b1; CSB = 1'b1;
    cyc(1'b0);
  endtask

  task automatic cpu_read(input logic [12:0] addr, output logic [7:0] data, output logic oe);
    A = addr; CSB = 1'b0; RDB = 1'b0;
    #1 oe = DB_OE;
    cyc(1'b0); cyc(1'b0);
    data = DB_O;
    RDB = 1'b1; CSB = 1'b1;
    cyc(1'b0);
  endtask

  task automatic run_lines(input logic [23:0] exp, output int de_n, output int bad);
    de_n = 0; bad = 0;
    for (int k = 0; k < 520; k++) begin
      cyc(1'b1);
      if (DE) begin
        de_n++;
        if (RGB !== exp) bad++;
      end
    end
  endtask

  logic [7:0]  d;
  logic        oe;
  int          t_a, t_b, rises, de_cnt, hs_cnt, vs_cnt, de_run, hs_run, rgb_bad;
  logic        de_prev, de_done, hs_done;
  logic [23:0] pix [8];
  int          de_n, bad;

  initial begin
    RES = 1'b1; CE = 1'b0; A = '0; DB_I = '0; RDB = 1'b1; WRB = 1'b1; CSB = 1'b1;
    VAD_I = 8'h3C; VBD_I = 8'hC3;
    @(negedge CLK);
    repeat (4) cyc(1'b1);
    check("rst_de",   32'(DE),   32'h0);
    check("rst_hs",   32'(HS),   32'h0);
    check("rst_vs",   32'(VS),   32'h0);
    check("rst_rgb",  32'(RGB),  32'h0);
    check("rst_db_o", 32'(DB_O), 32'h0);
    RES = 1'b0;
    cyc(1'b0);

    // A write overlapping reset must be dropped.
    cpu_write(13'h1005, 8'h11);
    RES = 1'b1;
    cpu_write(13'h1005, 8'h77);
    RES = 1'b0;
    cpu_read(13'h1005, d, oe);
    check("rst_drops_write", 32'(d), 32'h11);

    // Registers and DB_OE behaviour.
    A = 13'h1400; DB_I = 8'h03; CSB = 1'b0; WRB = 1'b0;
    #1 check("oe_during_write", 32'(DB_OE), 32'h0);
    cpu_write(13'h1400, 8'h03);
    cpu_write(13'h1401, 8'hF0);
    cpu_read(13'h1400, d, oe);
    check("r0_read", 32'(d),  32'h03);
    check("r0_oe",   32'(oe), 32'h1);
    #1 check("oe_idle", 32'(DB_OE), 32'h0);
    cpu_read(13'h1401, d, oe);
    check("r1_read", 32'(d), 32'hF0);

    // VRAM A (even byte) then VRAM B (odd byte).
    A = 13'h0004; DB_I = 8'h5A; CSB = 1'b0; WRB = 1'b0;
    #1;
    check("va_wr_n",  32'(nVAWR), 32'h0);
    check("va_addr",  32'(VAA),   32'h002);
    check("va_data",  32'(VAD_O), 32'h5A);
    check("vb_idle",  32'(nVBWR), 32'h1);
    cpu_write(13'h0004, 8'h5A);
    A = 13'h0005; DB_I = 8'hA5; CSB = 1'b0; WRB = 1'b0;
    #1;
    check("vb_wr_n",  32'(nVBWR), 32'h0);
    check("vb_addr",  32'(VBA),   32'h002);
    check("vb_data",  32'(VBD_O), 32'hA5);
    check("va_idle",  32'(nVAWR), 32'h1);
    cpu_write(13'h0005, 8'hA5);
    A = 13'h0004; CSB = 1'b0; RDB = 1'b0;
    #1;
    check("va_rd_n",  32'(nVARD), 32'h0);
    check("vb_rd_n",  32'(nVBRD), 32'h1);
    cpu_read(13'h0004, d, oe);
    check("va_read",  32'(d), 32'h3C);
    cpu_read(13'h0005, d, oe);
    check("vb_read",  32'(d), 32'hC3);

    // OAM byte lane and the unmapped window.
    cpu_write(13'h1203, 8'h12);
    check("oam_lane3", 32'(dut.oam[0][31:24]), 32'h12);
    cpu_read(13'h1203, d, oe);
    check("oam_read", 32'(d), 32'h12);
    cpu_write(13'h1500, 8'h99);
    cpu_read(13'h1400, d, oe);
    check("r0_after_1500", 32'(d), 32'h03);
    cpu_read(13'h1401, d, oe);
    check("r1_after_1500", 32'(d), 32'hF0);
    check("oam_after_1500", 32'(dut.oam[0][31:24]), 32'h12);
    cpu_read(13'h1500, d, oe);
    check("unmapped_read", 32'(d), 32'hFF);

    // Glyph 1, first pixel row lit in the MSB only.
    dut.chr[8] = 8'h80;
    cpu_write(13'h1000, 8'h01);

    // One full frame from the start of line 1 to line 1 of the next frame.
    t_a = -1; t_b = -1; rises = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    de_run = 0; hs_run = 0; rgb_bad = 0; de_done = 1'b0; hs_done = 1'b0;
    de_prev = DE;
    for (int n = 0; n < 70000; n++) begin
      cyc(1'b1);
      if (DE && !de_prev) begin
        if (t_a < 0) t_a = n;
        else begin
          rises++;
          if (rises == 256) begin
            t_b = n;
            break;
          end
        end
      end
      de_prev = DE;
      if (t_a >= 0) begin
        if (DE) de_cnt++;
        if (HS) hs_cnt++;
        if (VS) vs_cnt++;
        if (!DE && RGB !== '0) rgb_bad++;
        if (n - t_a < 8) pix[3'(n - t_a)] = RGB;
        if (!de_done) begin
          if (DE) de_run++;
          else de_done = 1'b1;
        end
        if (!hs_done) begin
          if (HS) hs_run++;
          else if (hs_run > 0) hs_done = 1'b1;
        end
      end
    end
    check("frame_found",  32'(t_b >= 0), 32'h1);
    check("frame_period", 32'(t_b - t_a), 32'd68120);
    check("de_per_line",  32'(de_run),    32'd192);
    check("de_per_frame", 32'(de_cnt),    32'd49152);
    check("hs_pulse",     32'(hs_run),    32'd20);
    check("hs_per_frame", 32'(hs_cnt),    32'd5240);
    check("vs_pulse",     32'(vs_cnt),    32'd780);
    check("rgb_blank",    32'(rgb_bad),   32'h0);
    check("pix0",         32'(pix[0]),    32'hFFFFFF);
    check("pix1",         32'(pix[1]),    32'h000000);
    check("pix4",         32'(pix[4]),    32'h000000);
    check("pix7",         32'(pix[7]),    32'h000000);

    // Display off forces black.
    cpu_write(13'h1400, 8'h00);
    run_lines(24'h000000, de_n, bad);
    check("off_de_count", 32'(de_n), 32'd384);
    check("off_black",    32'(bad),  32'h0);

    // Empty glyphs with index 8 background give dark grey.
    for (int i = 0; i < 1024; i++) dut.chr[i] = 8'h00;
    cpu_write(13'h1401, 8'h08);
    cpu_write(13'h1400, 8'h03);
    run_lines(24'h555555, de_n, bad);
    check("bg8_de_count", 32'(de_n), 32'd384);
    check("bg8_grey",     32'(bad),  32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
